// File: rtl/pll_phase_ctl.sv
// ECP5 EHXPLLL dynamic phase-shift sequencer: timed PHASESEL/DIR/STEP waveforms, lock qualification, per-output phase tracking.
// One request in flight (req_ready low while busy); `define PLL_PHASE_AUTORST_EN adds PLL reset + one retry on lock timeout.
module pll_phase_ctl #(
    parameter int STEP_W       = 8,
    parameter int PHASE_W      = 8,
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 4,
    parameter int GAP_CYC      = 4,
    parameter int LOCK_CYC     = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_sel,
    input  logic               req_dir,
    input  logic [STEP_W-1:0]  req_steps,
    input  logic               pll_locked,
    output logic [1:0]         pll_phasesel,
    output logic               pll_phasedir,
    output logic               pll_phasestep,
    output logic               pll_phaseloadreg,
    output logic               pll_rst,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               lock_ok,
    input  logic [1:0]         rd_sel,
    output logic [PHASE_W-1:0] rd_phase
);
    localparam int LK_W  = $clog2(LOCK_CYC + 1);
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STEP_LO, S_STEP_HI, S_WAIT_LOCK, S_DONE
`ifdef PLL_PHASE_AUTORST_EN
        , S_RECOVER
`endif
    } state_t;

    state_t              r_state;
    logic                r_rdy_en;
    logic [CNT_W-1:0]    r_cnt;
    logic [15:0]         r_to_cnt;
    logic [STEP_W-1:0]   r_remain;
    logic [1:0]          r_sel;
    logic                r_dir;
    logic                r_step;
    logic                r_done;
    logic                r_err;
    logic [PHASE_W-1:0]  r_phase [4];
    logic                r_lk_s1;
    logic                r_lk_s2;
    logic [LK_W-1:0]     r_lk_cnt;
    logic                r_lock_ok;
    logic                w_accept;
`ifdef PLL_PHASE_AUTORST_EN
    logic                r_rst;
    logic                r_retry;
`endif

    // LOCK is asynchronous to clk; qualification needs LOCK_CYC consecutive synchronized highs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lk_s1   <= 1'b0;
            r_lk_s2   <= 1'b0;
            r_lk_cnt  <= '0;
            r_lock_ok <= 1'b0;
        end else begin
            r_lk_s1 <= pll_locked;
            r_lk_s2 <= r_lk_s1;
            if (!r_lk_s2) begin
                r_lk_cnt  <= '0;
                r_lock_ok <= 1'b0;
            end else begin
                if (r_lk_cnt != LK_W'(LOCK_CYC))
                    r_lk_cnt <= r_lk_cnt + LK_W'(1);
                r_lock_ok <= (r_lk_cnt >= LK_W'(LOCK_CYC - 1));
            end
        end
    end

    assign w_accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_rdy_en <= 1'b0;
            r_cnt    <= '0;
            r_to_cnt <= '0;
            r_remain <= '0;
            r_sel    <= 2'd0;
            r_dir    <= 1'b1;
            r_step   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < 4; i++) r_phase[i] <= '0;
`ifdef PLL_PHASE_AUTORST_EN
            r_rst    <= 1'b0;
            r_retry  <= 1'b0;
`endif
        end else begin
            r_rdy_en <= 1'b1;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_sel    <= req_sel;
                    r_dir    <= req_dir;
                    r_remain <= req_steps;
                    r_err    <= 1'b0;
                    r_cnt    <= '0;
`ifdef PLL_PHASE_AUTORST_EN
                    r_retry  <= 1'b0;
`endif
                    r_state  <= (req_steps == '0) ? S_DONE : S_SETUP;
                end
                S_SETUP: if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
                    r_cnt   <= '0;
                    r_step  <= 1'b0;
                    r_state <= S_STEP_LO;
                end else r_cnt <= r_cnt + CNT_W'(1);
                S_STEP_LO: if (r_cnt == CNT_W'(PULSE_CYC - 1)) begin
                    r_cnt          <= '0;
                    r_step         <= 1'b1;
                    r_remain       <= r_remain - STEP_W'(1);
                    r_phase[r_sel] <= r_dir ? r_phase[r_sel] + PHASE_W'(1) : r_phase[r_sel] - PHASE_W'(1);
                    r_state        <= S_STEP_HI;
                end else r_cnt <= r_cnt + CNT_W'(1);
                S_STEP_HI: if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                    r_cnt    <= '0;
                    r_to_cnt <= '0;
                    if (r_remain != '0) begin
                        r_step  <= 1'b0;
                        r_state <= S_STEP_LO;
                    end else r_state <= S_WAIT_LOCK;
                end else r_cnt <= r_cnt + CNT_W'(1);
                S_WAIT_LOCK: if (r_lock_ok) begin
                    r_state <= S_DONE;
                end else if (r_to_cnt == 16'(LOCK_TIMEOUT - 1)) begin
`ifdef PLL_PHASE_AUTORST_EN
                    if (!r_retry) begin
                        r_retry <= 1'b1;
                        r_rst   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_RECOVER;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
`else
                    r_err   <= 1'b1;
                    r_state <= S_DONE;
`endif
                end else r_to_cnt <= r_to_cnt + 16'd1;
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
`ifdef PLL_PHASE_AUTORST_EN
                // A PLL reset restores the static phase, so the tracked offsets return to zero.
                S_RECOVER: begin
                    for (int i = 0; i < 4; i++) r_phase[i] <= '0;
                    if (r_cnt == CNT_W'(15)) begin
                        r_rst    <= 1'b0;
                        r_to_cnt <= '0;
                        r_state  <= S_WAIT_LOCK;
                    end else r_cnt <= r_cnt + CNT_W'(1);
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready        = (r_state == S_IDLE) && r_rdy_en;
    assign busy             = (r_state != S_IDLE);
    assign done             = r_done;
    assign err              = r_err;
    assign lock_ok          = r_lock_ok;
    assign pll_phasesel     = r_sel;
    assign pll_phasedir     = r_dir;
    assign pll_phasestep    = r_step;
    assign pll_phaseloadreg = 1'b1;
    assign rd_phase         = r_phase[rd_sel];
`ifdef PLL_PHASE_AUTORST_EN
    assign pll_rst          = r_rst;
`else
    assign pll_rst          = 1'b0;
`endif
endmodule

// File: tb/tb_pll_phase_ctl.sv
// Directed bench for pll_phase_ctl: request table plus hand-written lock-loss, timeout and reset sequences.
module tb_pll_phase_ctl;
    logic       clk = 1'b0;
    logic       resetn, req_valid, req_ready, req_dir, pll_locked;
    logic [1:0] req_sel, rd_sel, pll_phasesel;
    logic [7:0] req_steps, rd_phase;
    logic       pll_phasedir, pll_phasestep, pll_phaseloadreg, pll_rst, busy, done, err, lock_ok;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pll_phase_ctl #(.LOCK_TIMEOUT(100)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps), .pll_locked(pll_locked),
        .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir), .pll_phasestep(pll_phasestep),
        .pll_phaseloadreg(pll_phaseloadreg), .pll_rst(pll_rst), .busy(busy), .done(done),
        .err(err), .lock_ok(lock_ok), .rd_sel(rd_sel), .rd_phase(rd_phase)
    );

    typedef struct {
        logic [1:0] sel;
        logic       dir;
        logic [7:0] steps;
        int         exp_done;
        logic [7:0] exp_phase;
    } vec_t;

    vec_t tbl [6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic phase_of(input logic [1:0] s, output logic [7:0] p);
        rd_sel = s;
        #1;
        p = rd_phase;
    endtask

    // Issue one request and observe it cycle by cycle until done (bounded).
    task automatic run_req(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                           input int drop_c, input int rise_c, input bit poke,
                           output int pulses, output int first_fall, output bit width_ok,
                           output bit stable_ok, output int done_c, output int rst_cyc);
        int   c, lo_run, hi_run;
        logic prev;
        pulses = 0; first_fall = -1; width_ok = 1; stable_ok = 1; done_c = -1; rst_cyc = 0;
        lo_run = 0; hi_run = 0; prev = 1'b1; c = 0;
        req_sel = sel; req_dir = dir; req_steps = steps; req_valid = 1'b1;
        while (done_c < 0 && c < 400) begin
            tick;
            c++;
            if (c == 1) req_valid = 1'b0;
            if (poke && c == 20) begin req_valid = 1'b1; req_sel = ~sel; end
            if (poke && c == 25) req_valid = 1'b0;
            if (poke && c >= 21 && c <= 25 && req_ready !== 1'b0) stable_ok = 0;
            if (busy === 1'b1 && (pll_phasesel !== sel || pll_phasedir !== dir)) stable_ok = 0;
            if (pll_phasestep === 1'b0) begin
                if (prev) begin
                    pulses++;
                    if (first_fall < 0) first_fall = c;
                    else if (hi_run != 4) width_ok = 0;
                    lo_run = 0;
                end
                lo_run++;
            end else begin
                if (!prev) begin
                    if (lo_run != 4) width_ok = 0;
                    hi_run = 0;
                end
                hi_run++;
            end
            prev = pll_phasestep;
            if (pll_rst === 1'b1) rst_cyc++;
            if (done === 1'b1) done_c = c;
            if (c == drop_c) pll_locked = 1'b0;
            if (c == rise_c) pll_locked = 1'b1;
        end
    endtask

    initial begin
        int         pulses, ff, dc, rc;
        bit         wok, sok;
        logic [7:0] p;

        tbl[0] = '{2'd1, 1'b1, 8'd3, 29, 8'd3};
        tbl[1] = '{2'd2, 1'b0, 8'd1, 13, 8'd255};
        tbl[2] = '{2'd0, 1'b1, 8'd0,  2, 8'd0};
        tbl[3] = '{2'd3, 1'b1, 8'd2, 21, 8'd2};
        tbl[4] = '{2'd1, 1'b0, 8'd5, 45, 8'd254};
        tbl[5] = '{2'd2, 1'b1, 8'd1, 13, 8'd0};

        resetn = 1'b0; req_valid = 1'b0; req_sel = 2'd0; req_dir = 1'b0; req_steps = 8'd0;
        pll_locked = 1'b1; rd_sel = 2'd0;

        // Reset values, then lock qualification 2+16 cycles after release.
        repeat (3) tick;
        chk("rst_ready", req_ready, 0);
        chk("rst_sel", pll_phasesel, 0);
        chk("rst_dir", pll_phasedir, 1);
        chk("rst_step", pll_phasestep, 1);
        chk("rst_loadreg", pll_phaseloadreg, 1);
        chk("rst_pllrst", pll_rst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_lock_ok", lock_ok, 0);
        for (int s = 0; s < 4; s++) begin
            phase_of(2'(s), p);
            chk("rst_phase", p, 0);
        end
        resetn = 1'b1;
        tick;
        chk("ready_after_rst", req_ready, 1);
        chk("lock_ok_early", lock_ok, 0);
        repeat (16) tick;
        chk("lock_ok_c17", lock_ok, 0);
        tick;
        chk("lock_ok_c18", lock_ok, 1);

        // Request table with lock held.
        for (int i = 0; i < 6; i++) begin
            run_req(tbl[i].sel, tbl[i].dir, tbl[i].steps, -1, -1, 0, pulses, ff, wok, sok, dc, rc);
            chk("tbl_pulses", pulses, tbl[i].steps);
            chk("tbl_first_fall", ff, (tbl[i].steps == 0) ? -1 : 3);
            chk("tbl_widths", wok, 1);
            chk("tbl_sel_dir_stable", sok, 1);
            chk("tbl_done_cycle", dc, tbl[i].exp_done);
            chk("tbl_err", err, 0);
            phase_of(tbl[i].sel, p);
            chk("tbl_phase", p, tbl[i].exp_phase);
        end
        tick;
        chk("done_one_cycle", done, 0);

        // Lock lost mid-sequence, back after 40 cycles; request while busy is ignored.
        run_req(2'd0, 1'b1, 8'd1, 4, 44, 1, pulses, ff, wok, sok, dc, rc);
        chk("relock_pulses", pulses, 1);
        chk("relock_busy_ignore", sok, 1);
        chk("relock_done_cycle", dc, 64);
        chk("relock_err", err, 0);
        phase_of(2'd0, p);
        chk("relock_phase0", p, 1);

        // Lock held low: timeout path.
        pll_locked = 1'b0;
        repeat (4) tick;
        chk("lock_ok_dropped", lock_ok, 0);
        run_req(2'd3, 1'b1, 8'd1, -1, -1, 0, pulses, ff, wok, sok, dc, rc);
        chk("to_err", err, 1);
`ifdef PLL_PHASE_AUTORST_EN
        chk("to_done_cycle", dc, 228);
        chk("to_rst_cycles", rc, 16);
        phase_of(2'd3, p);
        chk("to_phase3", p, 0);
        phase_of(2'd1, p);
        chk("to_phase1", p, 0);
`else
        chk("to_done_cycle", dc, 112);
        chk("to_rst_cycles", rc, 0);
        phase_of(2'd3, p);
        chk("to_phase3", p, 3);
        phase_of(2'd1, p);
        chk("to_phase1", p, 254);
`endif
        repeat (3) tick;
        chk("err_sticky", err, 1);
        pll_locked = 1'b1;
        repeat (20) tick;
        run_req(2'd0, 1'b1, 8'd0, -1, -1, 0, pulses, ff, wok, sok, dc, rc);
        chk("err_cleared", err, 0);
        chk("zero_step_done", dc, 2);

        // Reset asserted during the second low pulse.
        req_sel = 2'd2; req_dir = 1'b0; req_steps = 8'd2; req_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (c == 1) req_valid = 1'b0;
        end
        chk("mid_step_low", pll_phasestep, 0);
        phase_of(2'd2, p);
        chk("mid_phase2", p, 255);
        resetn = 1'b0;
        tick;
        chk("mr_step", pll_phasestep, 1);
        chk("mr_busy", busy, 0);
        chk("mr_ready", req_ready, 0);
        chk("mr_sel", pll_phasesel, 0);
        chk("mr_dir", pll_phasedir, 1);
        chk("mr_lock_ok", lock_ok, 0);
        for (int s = 0; s < 4; s++) begin
            phase_of(2'(s), p);
            chk("mr_phase", p, 0);
        end
        resetn = 1'b1;
        tick;
        chk("mr_ready_after", req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
